// File: rtl/audio_pwm_out.sv
// audio_pwm_out: buffers signed 8-bit samples and plays them as 256-cycle-frame PWM.
// Latency: a buffered sample is loaded at pwm_cnt==255 and reaches pwm_out two cycles later.
// Backpressure: sample_ready_out is low while the buffer is full; underrun_out pulses if a frame starts empty.
//
// Ports:
//   clk_in           system clock, rising edge
//   rst_in           synchronous reset, active low
//   sample_in        signed two's-complement sample, qualified by sample_valid_in
//   sample_valid_in  producer offers sample_in this cycle
//   sample_ready_out buffer has room (registered state only)
//   pwm_out          registered PWM bit, high for 'duty' cycles of each 256-cycle frame
//   underrun_out     one-cycle pulse: the frame just started with an empty buffer
//   fill_out         buffer occupancy, 0..FIFO_DEPTH

module audio_pwm_out #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [7:0]                    sample_in,
    input  logic                          sample_valid_in,
    output logic                          sample_ready_out,
    output logic                          pwm_out,
    output logic                          underrun_out,
    output logic [$clog2(FIFO_DEPTH):0]   fill_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = AW + 1;
    localparam logic [FW-1:0] FULL_LVL = FW'(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    duty_q, duty_d;
    logic          pwm_q, pwm_d;
    logic          underrun_q, underrun_d;

    logic frame_end;
    logic push;
    logic pop;

    // Ready comes from the registered fill level only, so a pop in the same
    // cycle as a full buffer does not let a push through until the next cycle.
    assign sample_ready_out = (fill_q != FULL_LVL);
    assign frame_end        = (cnt_q == 8'hFF);
    assign push             = sample_valid_in && sample_ready_out;
    // Pop decision uses the pre-push fill, so a sample arriving on the frame
    // boundary into an empty buffer waits for the next boundary.
    assign pop              = frame_end && (fill_q != '0);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        duty_d     = duty_q;
        cnt_d      = cnt_q + 8'd1;
        // Compare uses the duty currently in effect; a duty loaded at count 255
        // therefore first shows up in the compare at count 0.
        pwm_d      = (cnt_q < duty_q);
        underrun_d = frame_end && (fill_q == '0);

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            // Signed sample to offset binary: -128 -> 0, 0 -> 128, +127 -> 255.
            duty_d   = mem_q[rd_ptr_q] ^ 8'h80;
        end

        case ({push, pop})
            2'b10:   fill_d = fill_q + FW'(1);
            2'b01:   fill_d = fill_q - FW'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            cnt_q      <= 8'd0;
            duty_q     <= 8'd128;
            pwm_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            pwm_q      <= pwm_d;
            underrun_q <= underrun_d;
        end
    end

    // Sample storage needs no reset: the pointers and fill level define validity.
    always_ff @(posedge clk_in) begin
        if (rst_in && push) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    assign pwm_out      = pwm_q;
    assign underrun_out = underrun_q;
    assign fill_out     = fill_q;

endmodule

// File: doc/audio_pwm_out.md
AUDIO_PWM_OUT -- requirements
Module: audio_pwm_out

Interface
- REQ-001: Parameter FIFO_DEPTH, default 4, sample buffer depth; SHALL be a power of two, at least 2.
- REQ-002: clk_in  input  1  system clock; all logic SHALL be on its rising edge.
- REQ-003: rst_in  input  1  synchronous reset, active-low; asserted (0) SHALL reset the block on the next rising clk_in.
- REQ-004: sample_in  input  8  signed two's-complement audio sample (generator output format).
- REQ-005: sample_valid_in  input  1  sample_in is valid this cycle.
- REQ-006: sample_ready_out  output  1  block accepts a sample this cycle.
- REQ-007: pwm_out  output  1  registered PWM audio bit.
- REQ-008: underrun_out  output  1  one-cycle pulse: a frame started with an empty buffer.
- REQ-009: fill_out  output  $clog2(FIFO_DEPTH)+1  current buffer occupancy, 0..FIFO_DEPTH.

Function
- REQ-010: The handshake SHALL complete (push) when sample_valid_in and sample_ready_out are both 1 on a rising edge; sample_in SHALL be written to the FIFO tail.
- REQ-011: sample_ready_out SHALL equal (fill_out != FIFO_DEPTH) and SHALL depend only on registered state (no combinational path from sample_valid_in).
- REQ-012: When full, a push SHALL NOT occur even if a pop happens in the same cycle; ready SHALL rise the cycle after the pop.
- REQ-013: An 8-bit frame counter pwm_cnt SHALL increment every cycle, 0..255, wrapping 255 -> 0; frame length is 256 cycles.
- REQ-014: On the cycle pwm_cnt == 255, the block SHALL load duty: if fill_out > 0, pop the FIFO head and set duty = sample XOR 8'h80 (offset binary, -128 -> 0, 0 -> 128, +127 -> 255).
- REQ-015: If fill_out == 0 on the cycle pwm_cnt == 255, duty SHALL hold its previous value and underrun_out SHALL be 1 on the following cycle only.
- REQ-016: Simultaneous push and pop SHALL leave fill_out unchanged and preserve FIFO order; a push into an empty FIFO in the same cycle as a frame boundary SHALL NOT be popped that cycle (underrun is reported).
- REQ-017: Every cycle, pwm_out SHALL be registered as (pwm_cnt < duty), using the duty in effect that cycle; a new duty loaded at pwm_cnt == 255 SHALL first apply to the comparison at pwm_cnt == 0.
- REQ-018: Per frame, pwm_out SHALL be high for exactly duty cycles: duty 0 -> always low; duty 255 -> high 255 of 256 cycles.
- REQ-019: FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; fill_out SHALL never exceed FIFO_DEPTH nor go below 0.
- REQ-020: Sample latency: a sample pushed into an empty FIFO SHALL drive pwm_out starting 2 cycles after the next pwm_cnt == 255 boundary (load, then register).

Reset
- REQ-021: With rst_in == 0 on a rising edge: fill_out = 0, pointers = 0, pwm_cnt = 0, duty = 128 (midscale silence), pwm_out = 0, underrun_out = 0, sample_ready_out = 1 from the next cycle.
- REQ-022: Reset mid-frame or with a non-empty FIFO SHALL discard all buffered samples; no pop or underrun pulse SHALL be produced by the reset itself.
- REQ-023: A push offered during reset SHALL be ignored.

Verification
- REQ-024: Reset then idle 3 frames -> pwm_out high 128 of every 256 cycles, underrun_out pulses once per frame (at pwm_cnt == 0).
- REQ-025: Push -128, 0, +127, -1 back-to-back after reset -> fill_out reaches 4, ready drops; successive frames show high counts 0, 128, 255, 127; then underrun with duty held at 127.
- REQ-026: Hold sample_valid_in high with FIFO full, one pop at frame boundary -> exactly one push, the cycle after the pop; order preserved.
- REQ-027: Push into empty FIFO on the cycle pwm_cnt == 255 -> underrun pulse next cycle; sample applied in the following frame.
- REQ-028: Assert rst_in low at pwm_cnt == 100 with fill_out == 3 -> after release fill_out = 0, pwm_cnt restarts at 0, duty 128, no underrun pulse in the reset cycle.
- REQ-029: Feed a 64-step triangle stream (one sample per frame) -> per-frame high counts match sample XOR 0x80, no underrun after the first frame.
